ref_cache_axi_read_master: RTL and testbench

REF_CACHE_AXI_READ_MASTER -- requirements
Module: ref_cache_axi_read_master

---
 rtl/ref_cache_axi_read_master_pkg.sv | 33 +++
 rtl/ref_cache_axi_read_master_addr_calc.sv | 36 +++
 rtl/ref_cache_axi_read_master.sv | 157 +++++++++++++++
 tb/tb_ref_cache_axi_read_master.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ref_cache_axi_read_master_pkg.sv
// Shared AXI / reference-cache definitions: AXI constant encodings, DPB layout
// offsets and the read-master state type.
package ref_cache_axi_read_master_pkg;

  localparam logic [2:0] AX_SIZE_64       = 3'b110;
  localparam logic [1:0] AX_BURST_INC     = 2'b01;
  localparam logic       AX_LOCK_DEFAULT  = 1'b0;
  localparam logic [3:0] AX_CACHE_DEFAULT = 4'b0011;
  localparam logic [2:0] AX_PROT_DATA     = 3'b000;

  localparam logic [1:0] XRESP_OKAY   = 2'b00;
  localparam logic [1:0] XRESP_EXOKAY = 2'b01;
  localparam logic [1:0] XRESP_SLVERR = 2'b10;
  localparam logic [1:0] XRESP_DECERR = 2'b11;

  // DPB layout: 8x8 block unit, block row inside a 64x64 CTU, CTU, CTU row
  localparam int DPB_BU_OFFSET     = 192;
  localparam int DPB_BU_ROW_OFFSET = 1536;
  localparam int DPB_IU_OFFSET     = 12288;
  localparam int DPB_IU_ROW_OFFSET = 98304;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_AR_SEND  = 2'd1,
    ST_R_RECV   = 2'd2,
    ST_LINE_OUT = 2'd3
  } rd_state_e;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == XRESP_SLVERR) || (resp == XRESP_DECERR);
  endfunction

endpackage

// File: rtl/ref_cache_axi_read_master_addr_calc.sv
// Combinational 8x8-block coordinate to DPB byte address generator; shared
// between the read and write sides of the reference cache.
module ref_pix_addr_calc
  import ref_cache_axi_read_master_pkg::*;
#(
  parameter int AXI_ADDR_WDTH = 32,
  parameter int BU_OFFSET     = DPB_BU_OFFSET,
  parameter int BU_ROW_OFFSET = DPB_BU_ROW_OFFSET,
  parameter int IU_OFFSET     = DPB_IU_OFFSET,
  parameter int IU_ROW_OFFSET = DPB_IU_ROW_OFFSET
) (
  input  logic [AXI_ADDR_WDTH-1:0] i_base,
  input  logic [7:0]               i_x_8x8,
  input  logic [7:0]               i_y_8x8,
  output logic [AXI_ADDR_WDTH-1:0] o_addr
);

  logic [AXI_ADDR_WDTH-1:0] w_x_ctu;
  logic [AXI_ADDR_WDTH-1:0] w_y_ctu;
  logic [AXI_ADDR_WDTH-1:0] w_x_in;
  logic [AXI_ADDR_WDTH-1:0] w_y_in;

  // Every term is widened to the address width first so the sum wraps cleanly
  always_comb begin
    w_x_ctu = AXI_ADDR_WDTH'(i_x_8x8[7:3]);
    w_y_ctu = AXI_ADDR_WDTH'(i_y_8x8[7:3]);
    w_x_in  = AXI_ADDR_WDTH'(i_x_8x8[2:0]);
    w_y_in  = AXI_ADDR_WDTH'(i_y_8x8[2:0]);
    o_addr  = i_base
            + w_y_ctu * AXI_ADDR_WDTH'(IU_ROW_OFFSET)
            + w_x_ctu * AXI_ADDR_WDTH'(IU_OFFSET)
            + w_y_in  * AXI_ADDR_WDTH'(BU_ROW_OFFSET)
            + w_x_in  * AXI_ADDR_WDTH'(BU_OFFSET);
  end

endmodule

// File: rtl/ref_cache_axi_read_master.sv
// Reference-cache AXI read master: turns one 8x8-block line request into a
// single INCR burst and returns the assembled cache line with an error flag.
module ref_cache_axi_read_master
  import ref_cache_axi_read_master_pkg::*;
#(
  parameter int AXI_ADDR_WDTH       = 32,
  parameter int AXI_CACHE_DATA_WDTH = 512,
  parameter int NUM_BEATS           = 3,
  parameter int BU_OFFSET           = DPB_BU_OFFSET,
  parameter int BU_ROW_OFFSET       = DPB_BU_ROW_OFFSET,
  parameter int IU_OFFSET           = DPB_IU_OFFSET,
  parameter int IU_ROW_OFFSET       = DPB_IU_ROW_OFFSET
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         req_valid,
  output logic                                         req_ready,
  input  logic [7:0]                                   req_x_8x8,
  input  logic [7:0]                                   req_y_8x8,
  input  logic [AXI_ADDR_WDTH-1:0]                     dpb_axi_addr_in,
  output logic                                         axi_arid,
  output logic [7:0]                                   axi_arlen,
  output logic [2:0]                                   axi_arsize,
  output logic [1:0]                                   axi_arburst,
  output logic                                         axi_arlock,
  output logic [3:0]                                   axi_arcache,
  output logic [2:0]                                   axi_arprot,
  output logic [AXI_ADDR_WDTH-1:0]                     axi_araddr,
  output logic                                         axi_arvalid,
  input  logic                                         axi_arready,
  input  logic [AXI_CACHE_DATA_WDTH-1:0]               axi_rdata,
  input  logic [1:0]                                   axi_rresp,
  input  logic                                         axi_rlast,
  input  logic                                         axi_rvalid,
  input  logic                                         axi_rid,
  output logic                                         axi_rready,
  output logic                                         line_valid,
  input  logic                                         line_ready,
  output logic [NUM_BEATS*AXI_CACHE_DATA_WDTH-1:0]     line_data,
  output logic                                         line_err,
  output logic [7:0]                                   line_x_8x8,
  output logic [7:0]                                   line_y_8x8
);

  localparam int DW     = AXI_CACHE_DATA_WDTH;
  localparam int BEAT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

  rd_state_e                     r_state;
  rd_state_e                     w_state_nxt;
  logic [BEAT_W-1:0]             r_beat;
  logic                          r_line_err;
  logic [AXI_ADDR_WDTH-1:0]      r_araddr;
  logic [AXI_ADDR_WDTH-1:0]      w_addr;
  logic [7:0]                    r_x;
  logic [7:0]                    r_y;
  logic [NUM_BEATS*DW-1:0]       r_line_data;
  logic                          w_req_hs;
  logic                          w_ar_hs;
  logic                          w_r_hs;
  logic                          w_line_hs;
  logic                          w_last_beat;
  logic                          w_beat_err;

  ref_pix_addr_calc #(
    .AXI_ADDR_WDTH (AXI_ADDR_WDTH),
    .BU_OFFSET     (BU_OFFSET),
    .BU_ROW_OFFSET (BU_ROW_OFFSET),
    .IU_OFFSET     (IU_OFFSET),
    .IU_ROW_OFFSET (IU_ROW_OFFSET)
  ) u_addr_calc (
    .i_base  (dpb_axi_addr_in),
    .i_x_8x8 (req_x_8x8),
    .i_y_8x8 (req_y_8x8),
    .o_addr  (w_addr)
  );

  assign w_req_hs    = req_valid && req_ready;
  assign w_ar_hs     = axi_arvalid && axi_arready;
  assign w_r_hs      = axi_rvalid && axi_rready;
  assign w_line_hs   = line_valid && line_ready;
  assign w_last_beat = (r_beat == LAST_BEAT);
  // rlast must coincide exactly with the final counted beat
  assign w_beat_err  = resp_is_err(axi_rresp) || axi_rid ||
                       (axi_rlast != w_last_beat);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (w_req_hs) w_state_nxt = ST_AR_SEND;
      ST_AR_SEND:  if (w_ar_hs) w_state_nxt = ST_R_RECV;
      ST_R_RECV:   if (w_r_hs && (w_last_beat || axi_rlast)) w_state_nxt = ST_LINE_OUT;
      ST_LINE_OUT: if (w_line_hs) w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = 1'b0;
    axi_arvalid = 1'b0;
    axi_rready  = 1'b0;
    line_valid  = 1'b0;
    case (r_state)
      ST_IDLE:     req_ready   = !reset;
      ST_AR_SEND:  axi_arvalid = 1'b1;
      ST_R_RECV:   axi_rready  = 1'b1;
      ST_LINE_OUT: line_valid  = 1'b1;
      default:     ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat     <= '0;
      r_line_err <= 1'b0;
    end else if ((r_state == ST_AR_SEND) && w_ar_hs) begin
      r_beat     <= '0;
      r_line_err <= 1'b0;
    end else if ((r_state == ST_R_RECV) && w_r_hs) begin
      r_beat <= r_beat + BEAT_W'(1);
      if (w_beat_err) r_line_err <= 1'b1;
    end
  end

  // Datapath registers carry no reset; they are qualified by the handshakes
  always_ff @(posedge clk) begin
    if (w_req_hs) begin
      r_araddr <= w_addr;
      r_x      <= req_x_8x8;
      r_y      <= req_y_8x8;
    end
    if ((r_state == ST_R_RECV) && w_r_hs) begin
      for (int b = 0; b < NUM_BEATS; b++) begin
        if (r_beat == BEAT_W'(b)) r_line_data[b*DW +: DW] <= axi_rdata;
      end
    end
  end

  assign axi_arid    = 1'b0;
  assign axi_arlen   = 8'(NUM_BEATS - 1);
  assign axi_arsize  = AX_SIZE_64;
  assign axi_arburst = AX_BURST_INC;
  assign axi_arlock  = AX_LOCK_DEFAULT;
  assign axi_arcache = AX_CACHE_DEFAULT;
  assign axi_arprot  = AX_PROT_DATA;
  assign axi_araddr  = r_araddr;
  assign line_data   = r_line_data;
  assign line_err    = r_line_err;
  assign line_x_8x8  = r_x;
  assign line_y_8x8  = r_y;

endmodule

// File: tb/tb_ref_cache_axi_read_master.sv
// Scoreboard bench for ref_cache_axi_read_master: randomized requests, an AXI
// slave model and a line monitor checking against a behavioural address model.
module tb_ref_cache_axi_read_master;

  localparam int AW = 32;
  localparam int DW = 512;
  localparam int NB = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [7:0]        req_x_8x8, req_y_8x8;
  logic [AW-1:0]     dpb_axi_addr_in;
  logic              axi_arid;
  logic [7:0]        axi_arlen;
  logic [2:0]        axi_arsize;
  logic [1:0]        axi_arburst;
  logic              axi_arlock;
  logic [3:0]        axi_arcache;
  logic [2:0]        axi_arprot;
  logic [AW-1:0]     axi_araddr;
  logic              axi_arvalid, axi_arready;
  logic [DW-1:0]     axi_rdata;
  logic [1:0]        axi_rresp;
  logic              axi_rlast, axi_rvalid, axi_rid, axi_rready;
  logic              line_valid, line_ready;
  logic [NB*DW-1:0]  line_data;
  logic              line_err;
  logic [7:0]        line_x_8x8, line_y_8x8;

  always #5 clk = ~clk;

  ref_cache_axi_read_master #(
    .AXI_ADDR_WDTH(AW), .AXI_CACHE_DATA_WDTH(DW), .NUM_BEATS(NB)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x_8x8(req_x_8x8), .req_y_8x8(req_y_8x8), .dpb_axi_addr_in(dpb_axi_addr_in),
    .axi_arid(axi_arid), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arlock(axi_arlock), .axi_arcache(axi_arcache),
    .axi_arprot(axi_arprot), .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rid(axi_rid),
    .axi_rready(axi_rready), .line_valid(line_valid), .line_ready(line_ready),
    .line_data(line_data), .line_err(line_err),
    .line_x_8x8(line_x_8x8), .line_y_8x8(line_y_8x8)
  );

  // kind: 0 clean, 1 bad rresp on beat k, 2 rid!=0 on beat k, 3 early rlast on beat k, 4 no rlast on last beat
  typedef struct packed {
    logic [31:0]       addr;
    logic [2:0]        kind;
    logic [1:0]        k;
    logic              ar_always;
    logic [3:0]        ar_delay;
    logic              r_always;
    logic [NB*DW-1:0]  data;
  } plan_t;

  typedef struct packed {
    logic [7:0]        x;
    logic [7:0]        y;
    logic              err;
    logic [3:0]        nbeats;
    logic [NB*DW-1:0]  data;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    checks = 0;
  int    failures = 0;
  logic  lr_block = 1'b0;
  logic  lr_always = 1'b1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] model_addr(input int x, input int y, input logic [31:0] base);
    longint a;
    a = longint'(base) + longint'((y / 8) * 98304) + longint'((x / 8) * 12288)
      + longint'((y % 8) * 1536) + longint'((x % 8) * 192);
    return a[31:0];
  endfunction

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic send_req(input int x, input int y, input logic [31:0] base, input int kind,
                          input int k, input bit ar_always, input int ar_delay, input bit r_always);
    plan_t p;
    exp_t  e;
    int    t;
    bit    ok;
    for (int b = 0; b < NB; b++) p.data[b*DW +: DW] = rand_beat();
    p.addr      = model_addr(x, y, base);
    p.kind      = 3'(kind);
    p.k         = 2'(k);
    p.ar_always = ar_always;
    p.ar_delay  = 4'(ar_delay);
    p.r_always  = r_always;
    e.x      = 8'(x);
    e.y      = 8'(y);
    e.err    = (kind != 0);
    e.nbeats = (kind == 3) ? 4'(k + 1) : 4'(NB);
    e.data   = p.data;
    @(posedge clk); #1;
    req_valid = 1'b1; req_x_8x8 = 8'(x); req_y_8x8 = 8'(y); dpb_axi_addr_in = base;
    t = 0; ok = 1'b0;
    while (t < 500) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
      t++;
    end
    chk("req_accept_timeout", ok, 1'b1);
    if (ok) begin
      plan_q.push_back(p);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || plan_q.size() != 0) && t < 3000) begin
      @(negedge clk); t++;
    end
    chk("idle_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  // AXI slave model: samples on negedge, drives just after posedge
  initial begin : slave
    plan_t cur;
    int    beat = 0, ar_cnt = 0, ar_wait = 0;
    bit    in_r = 0, hold = 0, ar_hs, r_hs, rst_s, av_s, term;
    logic [31:0] hold_addr = '0;
    cur = '0;
    axi_arready = 0; axi_rvalid = 0; axi_rdata = '0; axi_rresp = 0; axi_rlast = 0; axi_rid = 0;
    forever begin
      @(negedge clk);
      rst_s = reset;
      av_s  = axi_arvalid;
      ar_hs = axi_arvalid && axi_arready;
      r_hs  = axi_rvalid && axi_rready;
      if (!rst_s) begin
        chk("rready_outside_burst", axi_rready && !in_r, 1'b0);
        if (hold) begin
          chk("arvalid_held", axi_arvalid, 1'b1);
          chk("araddr_stable", axi_araddr, hold_addr);
        end
        if (axi_arvalid && !axi_arready) begin
          hold = 1; hold_addr = axi_araddr; ar_wait++;
        end else hold = 0;
        if (r_hs) begin
          chk("rbeat_unexpected", in_r, 1'b1);
          term = (cur.kind == 3 && beat == int'(cur.k)) || (beat == NB - 1);
          beat++;
          if (term) in_r = 0;
        end
        if (ar_hs) begin
          chk("ar_unexpected", plan_q.size() > 0, 1'b1);
          if (plan_q.size() > 0) begin
            cur = plan_q.pop_front();
            chk("araddr", axi_araddr, cur.addr);
            chk("arlen", axi_arlen, NB - 1);
            chk("arsize", axi_arsize, 3'b110);
            chk("arburst", axi_arburst, 2'b01);
            chk("arid", axi_arid, 1'b0);
            chk("ar_wait_cycles", ar_wait, cur.ar_always ? 0 : int'(cur.ar_delay) + 1);
            in_r = 1; beat = 0;
          end
          ar_wait = 0; ar_cnt = 0;
        end
      end
      @(posedge clk); #1;
      if (rst_s) begin
        in_r = 0; hold = 0; ar_wait = 0; ar_cnt = 0;
        axi_arready = 0; axi_rvalid = 0; axi_rlast = 0;
        continue;
      end
      if (plan_q.size() > 0 && !ar_hs) begin
        if (plan_q[0].ar_always) axi_arready = 1;
        else if (av_s) begin
          axi_arready = (ar_cnt >= int'(plan_q[0].ar_delay));
          ar_cnt++;
        end else axi_arready = 0;
      end else axi_arready = 0;
      if (r_hs || !axi_rvalid) begin
        if (in_r && (cur.r_always || $urandom_range(0, 3) != 0)) begin
          axi_rvalid = 1;
          axi_rdata  = cur.data[beat*DW +: DW];
          axi_rresp  = (cur.kind == 1 && beat == int'(cur.k)) ?
                       ($urandom_range(0, 1) ? 2'b10 : 2'b11) : 2'($urandom_range(0, 1));
          axi_rid    = (cur.kind == 2 && beat == int'(cur.k));
          axi_rlast  = (cur.kind == 3 && beat == int'(cur.k)) || (beat == NB - 1 && cur.kind != 4);
        end else begin
          axi_rvalid = 0; axi_rlast = 0;
        end
      end
    end
  end

  initial begin : line_ready_drv
    line_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      line_ready = lr_block ? 1'b0 : (lr_always ? 1'b1 : ($urandom_range(0, 2) != 0));
    end
  end

  // Scoreboard monitor: pops the expected line on every line handshake
  initial begin : line_mon
    bit pend = 0;
    logic [NB*DW-1:0] hd = '0;
    logic he = 0;
    logic [7:0] hx = 0, hy = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin pend = 0; continue; end
      if (pend) begin
        chk("line_valid_held", line_valid, 1'b1);
        chk("line_err_stable", line_err, he);
        chk("line_x_stable", line_x_8x8, hx);
        chk("line_y_stable", line_y_8x8, hy);
        for (int b = 0; b < NB; b++) chk("line_data_stable", line_data[b*DW +: DW], hd[b*DW +: DW]);
      end
      pend = 0;
      if (line_valid) begin
        chk("req_ready_during_line", req_ready, 1'b0);
        hd = line_data; he = line_err; hx = line_x_8x8; hy = line_y_8x8;
        if (line_ready) begin
          chk("line_unexpected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("line_err", line_err, e.err);
            chk("line_x", line_x_8x8, e.x);
            chk("line_y", line_y_8x8, e.y);
            for (int b = 0; b < int'(e.nbeats); b++)
              chk("line_data", line_data[b*DW +: DW], e.data[b*DW +: DW]);
          end
        end else pend = 1;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lat, t, kind, k;
    reset = 1'b1; req_valid = 1'b0; req_x_8x8 = 0; req_y_8x8 = 0; dpb_axi_addr_in = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_arvalid", axi_arvalid, 1'b0);
    chk("rst_rready", axi_rready, 1'b0);
    chk("rst_line_valid", line_valid, 1'b0);
    chk("rst_line_err", line_err, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", req_ready, 1'b1);

    // x=9,y=2 with everything ready: fixed address and minimum latency
    send_req(9, 2, 32'h1000_0000, 0, 0, 1, 0, 1);
    lat = 0;
    while (lat < 50) begin
      @(negedge clk); lat++;
      if (lat == 1) chk("araddr_x9y2", axi_araddr, 32'h1000_3CC0);
      if (line_valid) break;
    end
    chk("latency", lat, NB + 2);
    chk("line_err_clean", line_err, 1'b0);
    @(negedge clk);
    chk("line_same_cycle_accept", line_valid, 1'b0);
    wait_idle();

    // arready held low, then error lines, then a clean line clears line_err
    send_req(17, 40, 32'h2000_0000, 0, 0, 0, 9, 1);
    wait_idle();
    send_req(3, 5, 32'h0040_0000, 1, 1, 1, 0, 0);
    send_req(4, 6, 32'h0040_0000, 0, 0, 1, 0, 0);
    wait_idle();
    send_req(63, 7, 32'h0, 3, 1, 1, 0, 1);
    wait_idle();
    chk("idle_after_early_rlast", req_ready, 1'b1);
    send_req(255, 255, 32'hFFFF_0000, 4, 0, 0, 2, 0);
    send_req(1, 200, 32'h8000_0040, 2, 2, 1, 1, 1);
    wait_idle();

    // line_ready held off while a second request waits
    lr_block = 1'b1;
    send_req(10, 20, 32'h0100_0000, 0, 0, 1, 0, 1);
    fork
      send_req(11, 21, 32'h0100_0000, 0, 0, 1, 0, 1);
      begin
        t = 0;
        while (!line_valid && t < 100) begin @(negedge clk); t++; end
        chk("blocked_line_present", line_valid, 1'b1);
        repeat (8) begin
          @(negedge clk);
          chk("req_ready_blocked", req_ready, 1'b0);
        end
        @(posedge clk); #1 lr_block = 1'b0;
      end
    join
    wait_idle();

    // reset pulse while beat 1 is on the bus
    send_req(5, 9, 32'h3000_0000, 0, 0, 1, 0, 1);
    t = 0;
    while (t < 100) begin
      @(negedge clk); t++;
      if (axi_rvalid && axi_rready) break;
    end
    chk("beat0_seen", axi_rvalid && axi_rready, 1'b1);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("midrst_req_ready", req_ready, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_arvalid", axi_arvalid, 1'b0);
    chk("midrst_rready", axi_rready, 1'b0);
    chk("midrst_line_valid", line_valid, 1'b0);
    chk("midrst_line_err", line_err, 1'b0);
    chk("midrst_idle", req_ready, 1'b1);
    exp_q.delete();
    plan_q.delete();
    send_req(6, 9, 32'h3000_0000, 0, 0, 1, 0, 1);
    wait_idle();

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 7);
      if (kind > 4) kind = 0;
      k = (kind == 3) ? $urandom_range(0, NB - 2) : $urandom_range(0, NB - 1);
      lr_always = $urandom_range(0, 1);
      send_req($urandom_range(0, 255), $urandom_range(0, 255), $urandom, kind, k,
               $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1));
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
